// File: rtl/sop_sweep_eval.sv
// Registered sum-of-products evaluator with a live path and an exhaustive
// truth-table sweeper that streams f(x) for every x and counts the minterms.
module sop_sweep_eval #(
  parameter int N = 3,
  parameter int P = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [P*N-1:0]   term_care,
  input  logic [P*N-1:0]   term_val,
  input  logic [P-1:0]     term_en,
  input  logic [N-1:0]     in_vec,
  input  logic             start,
  output logic             f_live,
  output logic             busy,
  output logic             sweep_valid,
  output logic [N-1:0]     sweep_idx,
  output logic             sweep_f,
  output logic [N:0]       ones_count,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [N-1:0]       idx_reg, idx_next;
  logic               busy_reg, busy_next;
  logic               valid_reg, valid_next;
  logic [N-1:0]       sidx_reg, sidx_next;
  logic               sf_reg, sf_next;
  logic [N:0]         ones_reg, ones_next;
  logic               done_reg, done_next;
  logic               f_live_reg;
  logic               load_snap;

  logic [P*N-1:0]     care_s_reg, val_s_reg;
  logic [P-1:0]       en_s_reg;

  logic [P-1:0]       live_hit;
  logic [P-1:0]       snap_hit;
  logic               f_live_next;
  logic               f_snap;

  // One match term per product, evaluated for both the live vector and the sweep index.
  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_term
      assign live_hit[gi] = term_en[gi] &&
        (((in_vec ^ term_val[gi*N +: N]) & term_care[gi*N +: N]) == '0);
      assign snap_hit[gi] = en_s_reg[gi] &&
        (((idx_reg ^ val_s_reg[gi*N +: N]) & care_s_reg[gi*N +: N]) == '0);
    end
  endgenerate

  assign f_live_next = |live_hit;
  assign f_snap      = |snap_hit;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    busy_next  = busy_reg;
    valid_next = valid_reg;
    sidx_next  = sidx_reg;
    sf_next    = sf_reg;
    ones_next  = ones_reg;
    done_next  = 1'b0;
    load_snap  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          load_snap  = 1'b1;
          idx_next   = '0;
          ones_next  = '0;
          busy_next  = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        valid_next = 1'b1;
        sidx_next  = idx_reg;
        sf_next    = f_snap;
        ones_next  = ones_reg + (N+1)'(f_snap);
        // Terminate on the explicit last index so idx never wraps.
        if (idx_reg == {N{1'b1}}) begin
          state_next = S_DONE;
        end else begin
          idx_next = idx_reg + N'(1);
        end
      end
      S_DONE: begin
        valid_next = 1'b0;
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      idx_reg    <= '0;
      busy_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      sidx_reg   <= '0;
      sf_reg     <= 1'b0;
      ones_reg   <= '0;
      done_reg   <= 1'b0;
      f_live_reg <= 1'b0;
      care_s_reg <= '0;
      val_s_reg  <= '0;
      en_s_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      busy_reg   <= busy_next;
      valid_reg  <= valid_next;
      sidx_reg   <= sidx_next;
      sf_reg     <= sf_next;
      ones_reg   <= ones_next;
      done_reg   <= done_next;
      f_live_reg <= f_live_next;
      if (load_snap) begin
        care_s_reg <= term_care;
        val_s_reg  <= term_val;
        en_s_reg   <= term_en;
      end
    end
  end

  assign f_live      = f_live_reg;
  assign busy        = busy_reg;
  assign sweep_valid = valid_reg;
  assign sweep_idx   = sidx_reg;
  assign sweep_f     = sf_reg;
  assign ones_count  = ones_reg;
  assign done        = done_reg;

endmodule
